// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and helpers for the convolution unit and its
// load/store bridge.
//   CONV_TAG_W            width of the memory request/response tag
//   CONV_MAX_OUTSTANDING  default limit on reads in flight to memory
//   CONV_ADDR_W/DATA_W    address and data widths of the memory port
//   CONV_OPCODE_CUSTOM0   custom-0 major opcode decoded by conv_unit
//   conv_funct3_e         funct3 sub-operations of the custom-0 opcode
package conv_pkg;

    localparam int CONV_TAG_W           = 11;
    localparam int CONV_MAX_OUTSTANDING = 4;
    localparam int CONV_ADDR_W          = 32;
    localparam int CONV_DATA_W          = 32;

    localparam logic [6:0] CONV_OPCODE_CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {
        SETBASE = 3'b000,
        SETSIZE = 3'b001,
        RUN     = 3'b010
    } conv_funct3_e;

    // Memory is word-addressed on the wire; byte offset bits are dropped.
    function automatic logic [CONV_ADDR_W-1:0] conv_word_align(input logic [CONV_ADDR_W-1:0] addr);
        return {addr[CONV_ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic conv_misaligned(input logic [CONV_ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/conv_req_skid.sv
// conv_req_skid: one-entry holding register between the conv_unit read
// request and the memory read port. A held request is presented until the
// memory accepts it; a new request may be loaded in that same cycle, so a
// continuously accepting memory sees one request per clock.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-low
//   abort      drop the held request, refuse new ones this cycle
//   space_ok   downstream room available (in-flight limit, not discarding)
//   req_vld    request from conv_unit
//   req_addr   byte address of request
//   req_ready  request taken this cycle when high together with req_vld
//   mem_accept memory takes the held request this cycle
//   vld_p0     holding register occupied (drives the read strobe)
//   addr_p0    word-aligned address of held request
//   err_p0     held request was misaligned
//   issue      held request handed to memory this cycle
module conv_req_skid
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   abort,
    input  logic                   space_ok,
    input  logic                   req_vld,
    input  logic [CONV_ADDR_W-1:0] req_addr,
    output logic                   req_ready,
    input  logic                   mem_accept,
    output logic                   vld_p0,
    output logic [CONV_ADDR_W-1:0] addr_p0,
    output logic                   err_p0,
    output logic                   issue
);

    assign issue = vld_p0 & mem_accept;

    // Ready while held in reset or during an abort would advertise a request
    // that is about to be thrown away, so both gate it off.
    assign req_ready = rst & ~abort & space_ok & (~vld_p0 | mem_accept);

    // ---- stage p0: holding register ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0  <= 1'b0;
            addr_p0 <= '0;
            err_p0  <= 1'b0;
        end else if (abort) begin
            vld_p0 <= 1'b0;
        end else if (req_vld && req_ready) begin
            vld_p0  <= 1'b1;
            addr_p0 <= conv_word_align(req_addr);
            err_p0  <= conv_misaligned(req_addr);
        end else if (issue) begin
            vld_p0 <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_lsu_bridge.sv
// conv_lsu_bridge: turns conv_unit word reads into tagged, in-order reads on
// the data memory port, limits reads in flight, checks response tags and
// supports abandoning all outstanding reads.
// Parameters:
//   MAX_OUTSTANDING  reads in flight to memory (power of two, 2..8)
//   CACHEABLE        value driven on mem_cacheable_o
// Ports:
//   clk_i, rst_i          clock; synchronous active-low reset
//   lsu_req_i/addr_i      read request and byte address from conv_unit
//   lsu_req_ready_o       request accepted when high with lsu_req_i
//   lsu_data_valid_o      one-cycle pulse with returned word
//   lsu_data_o            returned word
//   lsu_error_o           bus error, tag mismatch or misaligned address
//   abort_i               abandon all outstanding reads
//   mem_rd_o/addr_o/req_tag_o   read request to memory
//   mem_wr_o, mem_cacheable_o   constant attributes
//   mem_accept_i          memory takes current read
//   mem_ack_i/error_i/resp_tag_i/data_rd_i   memory response
module conv_lsu_bridge
    import conv_pkg::*;
#(
    parameter int   MAX_OUTSTANDING = CONV_MAX_OUTSTANDING,
    parameter logic CACHEABLE       = 1'b1
)(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   lsu_req_i,
    input  logic [CONV_ADDR_W-1:0] lsu_addr_i,
    output logic                   lsu_req_ready_o,
    output logic                   lsu_data_valid_o,
    output logic [CONV_DATA_W-1:0] lsu_data_o,
    output logic                   lsu_error_o,
    input  logic                   abort_i,
    output logic                   mem_rd_o,
    output logic [CONV_ADDR_W-1:0] mem_addr_o,
    output logic [CONV_TAG_W-1:0]  mem_req_tag_o,
    output logic [3:0]             mem_wr_o,
    output logic                   mem_cacheable_o,
    input  logic                   mem_accept_i,
    input  logic                   mem_ack_i,
    input  logic                   mem_error_i,
    input  logic [CONV_TAG_W-1:0]  mem_resp_tag_i,
    input  logic [CONV_DATA_W-1:0] mem_data_rd_i
);

    localparam int               IDX_W   = $clog2(MAX_OUTSTANDING);
    localparam int               CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic                   hold_vld_p0;
    logic [CONV_ADDR_W-1:0] hold_addr_p0;
    logic                   hold_err_p0;
    logic                   issue;
    logic                   space_ok;

    logic [CNT_W-1:0] issue_seq;
    logic [CNT_W-1:0] rsp_seq;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_nxt;
    logic [CNT_W-1:0] discard;

    // Misaligned flag of each issued read, indexed by sequence number so the
    // response can pick it back up without sending it through memory.
    logic err_fifo [MAX_OUTSTANDING];

    logic ack_take;
    logic deliver;
    logic rsp_err;

    logic                   vld_p1;
    logic [CONV_DATA_W-1:0] data_p1;
    logic                   err_p1;

    // Counting the held entry against the limit keeps (in flight + held)
    // within MAX_OUTSTANDING, so a held read never has to wait for a slot
    // once it is presented to memory.
    assign space_ok = ((inflight + CNT_W'(hold_vld_p0)) < MAX_CNT) && (discard == '0);

    conv_req_skid u_skid (
        .clk        (clk_i),
        .rst        (rst_i),
        .abort      (abort_i),
        .space_ok   (space_ok),
        .req_vld    (lsu_req_i),
        .req_addr   (lsu_addr_i),
        .req_ready  (lsu_req_ready_o),
        .mem_accept (mem_accept_i),
        .vld_p0     (hold_vld_p0),
        .addr_p0    (hold_addr_p0),
        .err_p0     (hold_err_p0),
        .issue      (issue)
    );

    assign mem_rd_o        = hold_vld_p0;
    assign mem_addr_o      = hold_addr_p0;
    assign mem_req_tag_o   = CONV_TAG_W'(issue_seq);
    assign mem_wr_o        = 4'b0000;
    assign mem_cacheable_o = CACHEABLE;

    // Acks with nothing outstanding (e.g. leftovers from before a reset) are
    // not ours and leave every counter alone.
    assign ack_take = mem_ack_i & (inflight != '0);

    // Responses to abandoned reads, including one arriving in the abort
    // cycle itself, are consumed silently.
    assign deliver = ack_take & (discard == '0) & ~abort_i;

    assign rsp_err = mem_error_i
                   | (mem_resp_tag_i != CONV_TAG_W'(rsp_seq))
                   | err_fifo[rsp_seq[IDX_W-1:0]];

    always_comb begin
        inflight_nxt = inflight;
        if (issue && !ack_take) begin
            inflight_nxt = inflight + CNT_W'(1);
        end else if (!issue && ack_take) begin
            inflight_nxt = inflight - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue) begin
            err_fifo[issue_seq[IDX_W-1:0]] <= hold_err_p0;
        end
    end

    // ---- stage p1: response register ----
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            issue_seq <= '0;
            rsp_seq   <= '0;
            inflight  <= '0;
            discard   <= '0;
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            err_p1    <= 1'b0;
        end else begin
            inflight <= inflight_nxt;
            if (issue) begin
                issue_seq <= issue_seq + CNT_W'(1);
            end
            if (ack_take) begin
                rsp_seq <= rsp_seq + CNT_W'(1);
            end
            // Everything still outstanding after this cycle becomes discard;
            // no new reads can issue while discarding, so discard <= inflight.
            if (abort_i) begin
                discard <= inflight_nxt;
            end else if (ack_take && discard != '0) begin
                discard <= discard - CNT_W'(1);
            end
            vld_p1 <= deliver;
            err_p1 <= deliver & rsp_err;
            if (deliver) begin
                data_p1 <= mem_data_rd_i;
            end
        end
    end

    assign lsu_data_valid_o = vld_p1;
    assign lsu_data_o       = data_p1;
    assign lsu_error_o      = err_p1;

endmodule

// File: tb/tb_conv_lsu_bridge.sv
// Bench for conv_lsu_bridge: a memory responder with configurable accept and
// ack latency, plus a scoreboard of expected responses pushed as requests are
// accepted and popped as lsu_data_valid_o pulses.
module tb_conv_lsu_bridge;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic [31:0] lsu_addr_i;
    logic        lsu_req_ready_o;
    logic        lsu_data_valid_o;
    logic [31:0] lsu_data_o;
    logic        lsu_error_o;
    logic        abort_i;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic [10:0] mem_req_tag_o;
    logic [3:0]  mem_wr_o;
    logic        mem_cacheable_o;
    logic        mem_accept_i;
    logic        mem_ack_i;
    logic        mem_error_i;
    logic [10:0] mem_resp_tag_i;
    logic [31:0] mem_data_rd_i;

    always #5 clk = ~clk;

    conv_lsu_bridge #(.MAX_OUTSTANDING(4), .CACHEABLE(1'b1)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .lsu_req_i        (lsu_req_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_data_valid_o (lsu_data_valid_o),
        .lsu_data_o       (lsu_data_o),
        .lsu_error_o      (lsu_error_o),
        .abort_i          (abort_i),
        .mem_rd_o         (mem_rd_o),
        .mem_addr_o       (mem_addr_o),
        .mem_req_tag_o    (mem_req_tag_o),
        .mem_wr_o         (mem_wr_o),
        .mem_cacheable_o  (mem_cacheable_o),
        .mem_accept_i     (mem_accept_i),
        .mem_ack_i        (mem_ack_i),
        .mem_error_i      (mem_error_i),
        .mem_resp_tag_i   (mem_resp_tag_i),
        .mem_data_rd_i    (mem_data_rd_i)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [10:0] tag;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    exp_t  mon_e;
    pend_t rsp_p;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          acc_en = 1'b1;
    int          lat = 2;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          corrupt = 1'b0;
    logic [2:0]  exp_tag = 3'd0;
    bit          ack_prev = 1'b0;
    int          max_pend = 0;
    int          first_ack = -1;
    int          acc[6];
    int          t;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h0000_0141;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder and output monitor share one negedge process so the
    // monitor sees the ack value of the previous cycle before it is updated.
    initial begin
        mem_accept_i   = 1'b0;
        mem_ack_i      = 1'b0;
        mem_error_i    = 1'b0;
        mem_resp_tag_i = '0;
        mem_data_rd_i  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (lsu_data_valid_o) begin
                chk("vld_one_after_ack", 32'(ack_prev), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("spurious_vld", 32'(lsu_data_valid_o), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data", lsu_data_o, mon_e.data);
                    chk("rsp_err", 32'(lsu_error_o), 32'(mon_e.err));
                end
            end
            mem_accept_i = acc_en;
            if (!rst_i) begin
                exp_tag = 3'd0;
            end else if (mem_rd_o && acc_en) begin
                chk("req_tag", 32'(mem_req_tag_o), 32'(exp_tag));
                exp_tag++;
                rsp_p.addr = mem_addr_o;
                rsp_p.tag  = mem_req_tag_o;
                rsp_p.due  = cyc + lat;
                pend_q.push_back(rsp_p);
                if (pend_q.size() > max_pend) max_pend = pend_q.size();
            end
            mem_ack_i      = 1'b0;
            mem_error_i    = 1'b0;
            mem_resp_tag_i = '0;
            mem_data_rd_i  = '0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                rsp_p          = pend_q.pop_front();
                mem_ack_i      = 1'b1;
                mem_data_rd_i  = data_of(rsp_p.addr);
                mem_error_i    = (rsp_p.addr == err_addr);
                mem_resp_tag_i = rsp_p.tag ^ {10'b0, corrupt};
                corrupt        = 1'b0;
                if (first_ack < 0) first_ack = cyc;
            end
            ack_prev = mem_ack_i;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic xerr, output int acc_at);
        bit   done;
        exp_t te;
        done   = 1'b0;
        acc_at = -1;
        lsu_req_i  = 1'b1;
        lsu_addr_i = a;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk); #1;
            if (lsu_req_ready_o) begin
                te.data = data_of({a[31:2], 2'b00});
                te.err  = (a[1:0] != 2'b00) | xerr;
                exp_q.push_back(te);
                acc_at = cyc;
                done   = 1'b1;
            end
            @(posedge clk); #1;
        end
        lsu_req_i = 1'b0;
        chk("req_accepted", 32'(done), 32'd1);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_done", 32'(k < budget), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_mem_rd", 32'(mem_rd_o), 32'd0);
        chk("rst_ready", 32'(lsu_req_ready_o), 32'd0);
        chk("rst_vld", 32'(lsu_data_valid_o), 32'd0);
        chk("rst_err", 32'(lsu_error_o), 32'd0);
        chk("rst_data", lsu_data_o, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_tag", 32'(mem_req_tag_o), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst_i     = 1'b0;
        lsu_req_i = 1'b0;
        abort_i   = 1'b0;
        exp_q.delete();
        repeat (n) @(posedge clk);
        #1 rst_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i      = 1'b0;
        lsu_req_i  = 1'b0;
        lsu_addr_i = '0;
        abort_i    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_reset_outs();
        chk("rst_wr", 32'(mem_wr_o), 32'd0);
        chk("cacheable", 32'(mem_cacheable_o), 32'd1);
        @(posedge clk); #1 rst_i = 1'b1;
        @(negedge clk); #1;
        chk("ready_after_rst", 32'(lsu_req_ready_o), 32'd1);
        @(posedge clk); #1;

        // Single read at 0x144, data 0x5
        lat = 2;
        send(32'h144, 1'b0, t);
        chk("t1_rd", 32'(mem_rd_o), 32'd1);
        chk("t1_addr", mem_addr_o, 32'h144);
        chk("t1_tag", 32'(mem_req_tag_o), 32'd0);
        drain(50);

        // Six back-to-back reads, ack latency 10
        do_reset(2);
        max_pend  = 0;
        first_ack = -1;
        lat       = 10;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send(32'h1000 + 32'(i) * 4, 1'b0, acc[i]);
        drain(200);
        chk("t2_max_inflight", 32'(max_pend), 32'd4);
        chk("t2_b2b", 32'(acc[3] - acc[0]), 32'd3);
        chk("t2_wait_first_ack", 32'(acc[4] > first_ack), 32'd1);

        // Memory stalls for three cycles
        lat    = 2;
        acc_en = 1'b0;
        send(32'h2000, 1'b0, t);
        lsu_req_i  = 1'b1;
        lsu_addr_i = 32'h2004;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("t3_rd", 32'(mem_rd_o), 32'd1);
            chk("t3_addr", mem_addr_o, 32'h2000);
            chk("t3_tag", 32'(mem_req_tag_o), 32'(exp_tag));
            chk("t3_ready", 32'(lsu_req_ready_o), 32'd0);
            @(posedge clk); #1;
        end
        acc_en = 1'b1;
        send(32'h2004, 1'b0, t);
        drain(50);

        // Errors: misaligned, bus error, tag mismatch, then a clean read
        send(32'h146, 1'b0, t);
        chk("t4_align", mem_addr_o, 32'h144);
        drain(50);
        err_addr = 32'h200;
        send(32'h200, 1'b1, t);
        drain(50);
        err_addr = 32'hFFFF_FFFF;
        corrupt  = 1'b1;
        send(32'h300, 1'b1, t);
        drain(50);
        send(32'h304, 1'b0, t);
        drain(50);

        // Abort with three in flight and one held
        lat = 20;
        for (int i = 0; i < 3; i++) send(32'h3000 + 32'(i) * 4, 1'b0, t);
        @(posedge clk); #1;
        acc_en = 1'b0;
        chk("t5_inflight", 32'(pend_q.size()), 32'd3);
        send(32'h300C, 1'b0, t);
        abort_i = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        abort_i = 1'b0;
        acc_en  = 1'b1;
        @(negedge clk); #1;
        chk("t5_held_dropped", 32'(mem_rd_o), 32'd0);
        chk("t5_ready_discard", 32'(lsu_req_ready_o), 32'd0);
        for (int k = 0; k < 100 && pend_q.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        chk("t5_ready_last_ack", 32'(lsu_req_ready_o), 32'd0);
        @(negedge clk); #1;
        chk("t5_ready_back", 32'(lsu_req_ready_o), 32'd1);
        @(posedge clk); #1;
        lat = 3;
        send(32'h3100, 1'b0, t);
        drain(50);

        // Reset with two reads in flight; stray acks must be ignored
        lat = 20;
        send(32'h4000, 1'b0, t);
        send(32'h4004, 1'b0, t);
        @(posedge clk); #1;
        chk("t6_inflight", 32'(pend_q.size()), 32'd2);
        rst_i = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk); #1;
        chk_reset_outs();
        @(posedge clk); #1 rst_i = 1'b1;
        @(negedge clk); #1;
        chk("t6_ready_after_rst", 32'(lsu_req_ready_o), 32'd1);
        drain(100);
        lat = 2;
        send(32'h4100, 1'b0, t);
        chk("t6_tag0", 32'(mem_req_tag_o), 32'd0);
        drain(50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_lsu_bridge.md
CONV_LSU_BRIDGE -- requirements
Module: conv_lsu_bridge

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, max reads in flight to memory (power of two, 2..8).
REQ-002 SHALL have parameter CACHEABLE, default 1, driven on mem_cacheable_o.
REQ-003 clk_i  in  1  single clock, all logic on rising edge.
REQ-004 rst_i  in  1  synchronous, active-low reset.
REQ-005 lsu_req_i  in  1  read request from conv_unit.
REQ-006 lsu_addr_i  in  32  byte address of requested word.
REQ-007 lsu_req_ready_o  out  1  request accepted this cycle when high with lsu_req_i.
REQ-008 lsu_data_valid_o  out  1  one-cycle pulse, read data returned.
REQ-009 lsu_data_o  out  32  returned word.
REQ-010 lsu_error_o  out  1  qualifies lsu_data_valid_o; bus error or misaligned address.
REQ-011 abort_i  in  1  conv_unit abandons all outstanding reads.
REQ-012 mem_rd_o  out  1  read strobe to data memory port.
REQ-013 mem_addr_o  out  32  word-aligned read address.
REQ-014 mem_req_tag_o  out  11  request tag.
REQ-015 mem_wr_o  out  4  constant 0.
REQ-016 mem_cacheable_o  out  1  constant CACHEABLE.
REQ-017 mem_accept_i  in  1  memory accepts current mem_rd_o.
REQ-018 mem_ack_i  in  1  response valid.
REQ-019 mem_error_i  in  1  response carries error.
REQ-020 mem_resp_tag_i  in  11  response tag.
REQ-021 mem_data_rd_i  in  32  response data.

Function
REQ-022 Requests SHALL be captured in a one-entry holding register; lsu_req_ready_o = (holding empty or mem_accept_i) and in-flight count < MAX_OUTSTANDING and not discarding.
REQ-023 Accepted request SHALL drive mem_rd_o=1 the next cycle, held with stable addr/tag until mem_accept_i.
REQ-024 mem_addr_o SHALL be {lsu_addr_i[31:2],2'b00}; lsu_addr_i[1:0]!=0 SHALL set an error bit carried with the request.
REQ-025 mem_req_tag_o SHALL be {8'h00, issue sequence counter}, counter of width log2(MAX_OUTSTANDING)+1, incremented per mem_accept_i, wrapping.
REQ-026 Responses SHALL be in order; mem_ack_i with mem_resp_tag_i differing from the expected sequence value SHALL set lsu_error_o on that response.
REQ-027 lsu_data_valid_o/lsu_data_o/lsu_error_o SHALL be registered: asserted exactly one cycle after mem_ack_i; lsu_error_o = mem_error_i | tag mismatch | misaligned bit.
REQ-028 In-flight count SHALL increment on mem_rd_o&mem_accept_i, decrement on mem_ack_i; simultaneous events SHALL leave it unchanged.
REQ-029 Accept and a new request in the same cycle SHALL reload the holding register without bubble (1 request/cycle throughput).
REQ-030 abort_i SHALL clear the holding register (unaccepted request dropped); the current in-flight count becomes a discard count; subsequent acks SHALL decrement it without asserting lsu_data_valid_o.
REQ-031 While discard count nonzero, lsu_req_ready_o SHALL be 0; abort_i during discard SHALL add any newly accepted reads to it.
REQ-032 mem_ack_i with in-flight count 0 SHALL be ignored (no output pulse, counts unchanged).

Reset
REQ-033 While rst_i=0 at a clock edge: holding register empty, counters 0, mem_rd_o=0, lsu_req_ready_o=0, lsu_data_valid_o=0, lsu_error_o=0, lsu_data_o=0, mem_addr_o=0, mem_req_tag_o=0.
REQ-034 Reset mid-transaction SHALL forget in-flight reads; first cycle after release lsu_req_ready_o=1.

Structure
REQ-035 conv_pkg SHALL hold CONV_TAG_W=11, CONV_MAX_OUTSTANDING=4, custom-0 opcode 7'b0001011 and funct3 codes SETBASE=000, SETSIZE=001, RUN=010.
REQ-036 The holding register with its valid/ready logic SHALL be sub-module conv_req_skid; counters and response path stay in conv_lsu_bridge.

Verification
REQ-037 Single read addr 0x144, memory accepts immediately, ack 2 cycles later data 0x5 -> mem_addr_o=0x144, tag 0, lsu_data_valid_o one cycle after ack, data 0x5, error 0.
REQ-038 Back-to-back 6 requests, mem_accept_i=1, ack latency 10 -> exactly 4 issued, ready low until first ack, all 6 data returned in order, tags 0..5.
REQ-039 mem_accept_i held low 3 cycles -> mem_rd_o/addr/tag stable, ready low, then resumes with no request lost.
REQ-040 Address 0x146 -> mem_addr_o=0x144, response carries lsu_error_o=1; mem_error_i=1 on another read -> lsu_error_o=1.
REQ-041 abort_i with 3 reads in flight and 1 held -> held dropped, no lsu_data_valid_o for 3 acks, ready returns after third ack.
REQ-042 rst_i low with 2 reads in flight, then release -> all outputs at reset values, stray acks ignored, next request tag 0.
